// File: rtl/opb_multireg_pkg.sv
// Shared constants and helpers for the multi-channel simulink-to-PPC register bank.
package opb_multireg_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } opb_state_e;

    // CTRL/STATUS field positions as numeric bit indices (OPB bit 31 is numeric bit 0)
    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_MODE_BIT  = 1;
    localparam int CTRL_DONE_BIT  = 2;
    localparam int CTRL_COUNT_LSB = 16;
    localparam int CTRL_COUNT_W   = 16;

    // CTRL/STATUS sits directly after the last snapshot channel
    function automatic int ctrl_offset(input int num_regs);
        return num_regs;
    endfunction

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] high);
        return (addr >= base) && (addr <= high);
    endfunction

endpackage

// File: rtl/opb_multireg_capture.sv
// Coherent snapshot of all user channels plus arm/mode/done/count control state.
module opb_multireg_capture
    import opb_multireg_pkg::*;
#(
    parameter int C_NUM_REGS   = 4,
    parameter int C_USER_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [C_NUM_REGS*C_USER_WIDTH-1:0]     user_data_in,
    input  logic                                   user_valid,
    input  logic                                   ctrl_wr,
    input  logic                                   wr_arm,
    input  logic                                   wr_mode,
    output logic [C_NUM_REGS-1:0][C_USER_WIDTH-1:0] snap,
    output logic                                   armed,
    output logic                                   mode,
    output logic                                   done,
    output logic [CTRL_COUNT_W-1:0]                count
);

    // A strobe only captures if armed before this edge or running continuously;
    // an arm arriving on the same edge applies to later strobes only.
    logic capture;
    assign capture = user_valid & (armed | mode);

    // Snapshot load and control-state update on each strobe / CTRL write
    always_ff @(posedge clk) begin
        if (rst) begin
            snap  <= '0;
            armed <= 1'b0;
            mode  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
        end else begin
            if (capture) begin
                snap  <= user_data_in;
                count <= count + 1'b1;
            end
            // a software arm beats the one-shot self-clear
            if (ctrl_wr && wr_arm) begin
                armed <= 1'b1;
            end else if (capture && !mode) begin
                armed <= 1'b0;
            end
            if (capture) begin
                done <= 1'b1;
            end else if (ctrl_wr && wr_arm) begin
                done <= 1'b0;
            end
            if (ctrl_wr) begin
                mode <= wr_mode;
            end
        end
    end

endmodule

// File: rtl/opb_multireg_simulink2ppc.sv
// OPB slave exposing C_NUM_REGS coherently captured user channels plus CTRL/STATUS.
module opb_multireg_simulink2ppc
    import opb_multireg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01094800,
    parameter logic [31:0] C_HIGHADDR   = 32'h010948FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter int          C_USER_WIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                               OPB_Clk,
    input  logic                               OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]            OPB_ABus,
    input  logic [0:3]                         OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]            OPB_DBus,
    input  logic                               OPB_RNW,
    input  logic                               OPB_select,
    input  logic                               OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]            Sl_DBus,
    output logic                               Sl_xferAck,
    output logic                               Sl_errAck,
    output logic                               Sl_retry,
    output logic                               Sl_toutSup,
    input  logic [C_NUM_REGS*C_USER_WIDTH-1:0] user_data_in,
    input  logic                               user_valid,
    output logic                               snap_armed
);

    localparam int CTRL_OFF = ctrl_offset(C_NUM_REGS);
    localparam logic [55:0] family_unused = C_FAMILY;

    // Numeric (LSB = bit 0) views of the big-endian OPB buses
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] byte_off;
    logic [29:0] word_off;
    logic        hit;
    logic        start;
    logic        unused_bits;

    assign addr     = OPB_ABus;
    assign wdata    = OPB_DBus;
    assign be       = OPB_BE;
    assign byte_off = addr - C_BASEADDR;
    assign word_off = byte_off[31:2];
    assign hit      = OPB_select & addr_in_range(addr, C_BASEADDR, C_HIGHADDR);

    assign unused_bits = ^{OPB_seqAddr, be[3:1], wdata[31:2], byte_off[1:0]};

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic [C_NUM_REGS-1:0][C_USER_WIDTH-1:0] snap;
    logic                                   armed;
    logic                                   mode;
    logic                                   done;
    logic [CTRL_COUNT_W-1:0]                count;
    logic                                   ctrl_wr_p1;
    logic                                   wr_arm_p1;
    logic                                   wr_mode_p1;

    opb_multireg_capture #(
        .C_NUM_REGS   (C_NUM_REGS),
        .C_USER_WIDTH (C_USER_WIDTH)
    ) u_capture (
        .clk          (OPB_Clk),
        .rst          (OPB_Rst),
        .user_data_in (user_data_in),
        .user_valid   (user_valid),
        .ctrl_wr      (ctrl_wr_p1),
        .wr_arm       (wr_arm_p1),
        .wr_mode      (wr_mode_p1),
        .snap         (snap),
        .armed        (armed),
        .mode         (mode),
        .done         (done),
        .count        (count)
    );

    assign snap_armed = armed;

    opb_state_e state_p1;
    opb_state_e state_nxt;

    assign Sl_xferAck = (state_p1 == ST_ACK);
    assign start      = (state_p1 == ST_IDLE) && hit && !Sl_xferAck;

    // FSM state register
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_p1 <= ST_IDLE;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    // Next state: every hit gets exactly one ACK cycle, then a forced idle cycle
    always_comb begin
        state_nxt = state_p1;
        case (state_p1)
            ST_IDLE: if (hit && !Sl_xferAck) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read mux from the decoded offset; unmapped in-range offsets read 0
    logic [31:0] rd_data;
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word_off == 30'(i)) begin
                rd_data = 32'(snap[i]);
            end
        end
        if (word_off == 30'(CTRL_OFF)) begin
            rd_data[CTRL_COUNT_LSB +: CTRL_COUNT_W] = count;
            rd_data[CTRL_DONE_BIT]                  = done;
            rd_data[CTRL_MODE_BIT]                  = mode;
            rd_data[CTRL_ARM_BIT]                   = armed;
        end
    end

    // Register read data and the pending CTRL write at IDLE->ACK; both drop after ACK
    logic [31:0] dbus_p1;
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            dbus_p1    <= '0;
            ctrl_wr_p1 <= 1'b0;
        end else if (start) begin
            dbus_p1    <= OPB_RNW ? rd_data : 32'h0;
            ctrl_wr_p1 <= !OPB_RNW && (word_off == 30'(CTRL_OFF)) && be[0];
        end else begin
            dbus_p1    <= '0;
            ctrl_wr_p1 <= 1'b0;
        end
    end

    // CTRL write payload, qualified by ctrl_wr_p1
    always_ff @(posedge OPB_Clk) begin
        if (start) begin
            wr_arm_p1  <= wdata[CTRL_ARM_BIT];
            wr_mode_p1 <= wdata[CTRL_MODE_BIT];
        end
    end

    assign Sl_DBus = dbus_p1;

endmodule

// File: tb/tb_opb_multireg_simulink2ppc.sv
// Randomised scoreboard bench for the multi-channel OPB snapshot register bank.
module tb_opb_multireg_simulink2ppc;

    localparam int          N    = 4;
    localparam int          W    = 12;
    localparam logic [31:0] BASE = 32'h01094800;
    localparam logic [31:0] HIGH = 32'h010948FF;

    logic           clk = 1'b0;
    logic           rst;
    logic [0:31]    OPB_ABus;
    logic [0:3]     OPB_BE;
    logic [0:31]    OPB_DBus;
    logic           OPB_RNW;
    logic           OPB_select;
    logic           OPB_seqAddr;
    logic [0:31]    Sl_DBus;
    logic           Sl_xferAck;
    logic           Sl_errAck;
    logic           Sl_retry;
    logic           Sl_toutSup;
    logic [N*W-1:0] user_data_in;
    logic           user_valid;
    logic           snap_armed;

    always #5 clk = ~clk;

    opb_multireg_simulink2ppc #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_NUM_REGS   (N),
        .C_USER_WIDTH (W)
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .OPB_ABus     (OPB_ABus),
        .OPB_BE       (OPB_BE),
        .OPB_DBus     (OPB_DBus),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_seqAddr  (OPB_seqAddr),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_errAck    (Sl_errAck),
        .Sl_retry     (Sl_retry),
        .Sl_toutSup   (Sl_toutSup),
        .user_data_in (user_data_in),
        .user_valid   (user_valid),
        .snap_armed   (snap_armed)
    );

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_act;

    // Reference model state
    logic [W-1:0] snap_m[N];
    bit           armed_m, mode_m, done_m;
    logic [15:0]  count_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [29:0] off);
        if (off < N) return 32'(snap_m[int'(off)]);
        if (off == N) return {count_m, 13'b0, done_m, mode_m, armed_m};
        return 32'h0;
    endfunction

    // One clock edge of the behavioural model: strobe and/or CTRL write
    function automatic void model_edge(input bit uv, input logic [N*W-1:0] ud,
                                       input bit cw, input bit warm, input bit wmode);
        bit cap;
        cap = uv && (armed_m || mode_m);
        if (cap) begin
            for (int i = 0; i < N; i++) snap_m[i] = ud[i*W +: W];
            count_m = count_m + 16'd1;
        end
        if (cw && warm) armed_m = 1'b1;
        else if (cap && !mode_m) armed_m = 1'b0;
        if (cap) done_m = 1'b1;
        else if (cw && warm) done_m = 1'b0;
        if (cw) mode_m = wmode;
    endfunction

    // Monitor: every ack pops the scoreboard; bus must be 0 otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            mon_act = Sl_DBus;
            if (Sl_xferAck === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack with data %h expected no ack", mon_act);
                end else begin
                    chk("read_data", mon_act, exp_q.pop_front());
                end
            end else begin
                chk("dbus_zero_when_idle", mon_act, 32'h0);
            end
        end
    end

    // One OPB transfer; uv_phase 1 strobes in the hit cycle, 2 in the ACK cycle
    task automatic opb_xfer(input logic [31:0] addr, input bit rnw, input logic [31:0] wdata,
                            input logic [3:0] be, input int uv_phase, input logic [N*W-1:0] ud);
        bit          in_r;
        bit          cw;
        logic [31:0] bo;
        logic [29:0] off;
        in_r = (addr >= BASE) && (addr <= HIGH);
        bo   = addr - BASE;
        off  = bo[31:2];
        @(negedge clk);
        OPB_ABus = addr; OPB_RNW = rnw; OPB_DBus = wdata; OPB_BE = be; OPB_select = 1'b1;
        if (uv_phase == 1) begin user_valid = 1'b1; user_data_in = ud; end
        if (in_r) exp_q.push_back(rnw ? model_read(off) : 32'h0);
        @(posedge clk);
        model_edge(uv_phase == 1, ud, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ack_latency", 32'(Sl_xferAck), 32'(in_r));
        user_valid = (uv_phase == 2);
        if (uv_phase == 2) user_data_in = ud;
        @(posedge clk);
        cw = in_r && !rnw && (off == N) && be[0];
        model_edge(uv_phase == 2, ud, cw, wdata[0], wdata[1]);
        @(negedge clk);
        OPB_select = 1'b0; user_valid = 1'b0;
        chk("ack_one_cycle", 32'(Sl_xferAck), 32'h0);
        chk("snap_armed", 32'(snap_armed), 32'(armed_m));
    endtask

    task automatic strobe(input logic [N*W-1:0] ud);
        @(negedge clk);
        user_valid = 1'b1; user_data_in = ud;
        @(posedge clk);
        model_edge(1'b1, ud, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        user_valid = 1'b0;
        chk("snap_armed", 32'(snap_armed), 32'(armed_m));
    endtask

    task automatic read_all();
        for (int i = 0; i <= N; i++) opb_xfer(BASE + 32'(4*i), 1'b1, 32'h0, 4'hF, 0, '0);
    endtask

    function automatic logic [N*W-1:0] rand_ud();
        logic [N*W-1:0] ud;
        logic [31:0]    t;
        for (int i = 0; i < N; i++) begin
            t = $urandom;
            ud[i*W +: W] = t[W-1:0];
        end
        return ud;
    endfunction

    initial begin
        logic [N*W-1:0] ud;
        logic [31:0]    a;
        logic [31:0]    t;
        int             r;
        int             waited;

        for (int i = 0; i < N; i++) snap_m[i] = '0;
        armed_m = 0; mode_m = 0; done_m = 0; count_m = '0;
        rst = 1'b1; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
        OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_data_in = '0; user_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_xferack", 32'(Sl_xferAck), 32'h0);
        chk("reset_dbus", Sl_DBus, 32'h0);
        chk("reset_armed", 32'(snap_armed), 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset contents
        read_all();

        // One-shot arm then capture
        opb_xfer(BASE + 32'(4*N), 1'b0, 32'h00000001, 4'hF, 0, '0);
        ud = rand_ud();
        ud[0*W +: W] = W'(32'hDEADBEEF);
        ud[3*W +: W] = W'(32'h12345678);
        strobe(ud);
        read_all();

        // Unarmed strobes are ignored
        strobe(rand_ud());
        strobe(rand_ud());
        read_all();

        // Continuous mode: every strobe captures
        opb_xfer(BASE + 32'(4*N), 1'b0, 32'h00000002, 4'hF, 0, '0);
        repeat (3) strobe(rand_ud());
        read_all();

        // Full-scale channel value, then arm coincident with a strobe
        ud = rand_ud();
        ud[1*W +: W] = '1;
        strobe(ud);
        opb_xfer(BASE + 32'(4*N), 1'b0, 32'h00000000, 4'hF, 0, '0);
        opb_xfer(BASE + 32'(4*N), 1'b0, 32'h00000001, 4'hF, 2, rand_ud());
        read_all();

        // Arm write without BE[3] is ignored
        opb_xfer(BASE + 32'(4*N), 1'b0, 32'h00000003, 4'hE, 0, '0);
        read_all();

        // Read coincident with capture returns pre-capture value
        opb_xfer(BASE, 1'b1, 32'h0, 4'hF, 1, rand_ud());
        read_all();

        // Held select: ack on alternate cycles only
        @(negedge clk);
        OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_select = 1'b1; OPB_BE = 4'hF;
        exp_q.push_back(model_read(30'd0));
        exp_q.push_back(model_read(30'd0));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("held_select_ack", 32'(Sl_xferAck), 32'((k % 2) == 0));
        end
        OPB_select = 1'b0;

        // Unmapped in-range offset and out-of-range addresses
        opb_xfer(BASE + 32'h3C, 1'b1, 32'h0, 4'hF, 0, '0);
        opb_xfer(BASE + 32'h3C, 1'b0, 32'hFFFFFFFF, 4'hF, 0, '0);
        opb_xfer(HIGH + 32'd1, 1'b1, 32'h0, 4'hF, 0, '0);
        opb_xfer(BASE - 32'd4, 1'b1, 32'h0, 4'hF, 0, '0);

        // Randomised mix
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            t = $urandom;
            if (r <= 4) begin
                a = BASE + 32'(4*$urandom_range(0, N + 3)) + 32'($urandom_range(0, 3));
                opb_xfer(a, 1'b1, 32'h0, 4'hF, $urandom_range(0, 2), rand_ud());
            end else if (r <= 6) begin
                opb_xfer(BASE + 32'(4*N), 1'b0, t, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2), rand_ud());
            end else if (r <= 8) begin
                strobe(rand_ud());
            end else begin
                a = t[0] ? (HIGH + 32'($urandom_range(1, 64))) : (BASE - 32'($urandom_range(1, 64)));
                opb_xfer(a, t[1], t, 4'hF, 0, '0);
            end
        end
        read_all();

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opb_multireg_simulink2ppc.md
Name: opb_multireg_simulink2ppc

Overview:
Multi-channel, PPC-readable register bank on the OPB. It generalises the single simulink-to-PPC register to C_NUM_REGS user channels of parametrised width. All channels are captured coherently into a snapshot on a user strobe, either on software arm (one-shot) or on every strobe (continuous). It sits between Simulink user logic and the OPB, and is instantiated by a per-design wrapper.

Parameters:
C_BASEADDR, 32'h01094800, first byte address of the block
C_HIGHADDR, 32'h010948FF, last byte address; must satisfy HIGH-BASE+1 >= 4*(C_NUM_REGS+1)
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
C_NUM_REGS, 4, number of user channels (1..16)
C_USER_WIDTH, 32, bits per channel (1..32)
C_FAMILY, "virtex5", target family (passed through, no functional effect)

Ports:
OPB_Clk  in  1  sole clock; user logic is synchronous to it
OPB_Rst  in  1  synchronous, active-high reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1=read, 0=write
OPB_select  in  1  master transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; zero when not acking
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_data_in  in  C_NUM_REGS*C_USER_WIDTH  channel i occupies bits [i*W+W-1 : i*W]
user_valid  in  1  capture strobe, one cycle per sample
snap_armed  out  1  one-shot capture pending (for user-side debug)

Behaviour:
- One clock (OPB_Clk). Reset is synchronous, active-high on OPB_Rst.
- Reset values: Sl_DBus=0, Sl_xferAck=0, snap_armed=0; all snapshot regs=0, mode=0, done=0, count=0.
- Decode: hit = OPB_select & (C_BASEADDR <= OPB_ABus <= C_HIGHADDR); word offset = (OPB_ABus-C_BASEADDR)>>2.
- Register map, by word offset:
  - 0..N-1: snapshot of channel i, read-only, right-justified at Sl_DBus[32-W:31], upper bits 0.
  - N: CTRL/STATUS. Write: bit31 (Sl bit 31, LSB)=arm, bit30=continuous mode. Read: bit31=armed, bit30=mode, bit29=done, bits[0:15]=capture count (16-bit, wraps).
  - >N in range: reads 0, writes ignored, still acked.
- OPB FSM:
  - IDLE: hit & !Sl_xferAck -> ACK.
  - ACK: lasts exactly one cycle, Sl_xferAck=1, Sl_DBus=read data (reads) or 0 (writes); then returns to IDLE.
- Latency: xferAck rises 1 cycle after the hit is sampled. Back-to-back transfers are separated by at least one idle cycle, because select is still high during the ACK cycle and must not re-trigger.
- Read data is registered from the decoded offset in the IDLE->ACK transition.
- Sl_DBus is exactly 0 whenever Sl_xferAck=0 (wire-OR bus).
- CTRL write: takes effect at the ACK cycle. It is honoured only if OPB_BE[3]=1 (arm/mode byte). Writing arm=1 sets armed and clears done; arm=0 leaves armed unchanged. Mode bit is written whenever BE[3]=1.
- Capture: on user_valid & (armed | mode), all N channels load simultaneously from user_data_in on that edge, count+1, done=1. In one-shot mode, armed is cleared on the capture.
- Simultaneous arm write and user_valid in the same cycle: no capture from that strobe unless already armed; armed ends the cycle set (write wins over clear).
- A read of a snapshot reg in the same cycle as a capture returns the pre-capture value.
- Reset mid-transfer: FSM forced to IDLE and xferAck deasserted next cycle; master times out.

Decomposition:
- Package opb_multireg_pkg:
  - register offset constants (CTRL_OFFSET = C_NUM_REGS as function);
  - CTRL bit positions (ARM, MODE, DONE, COUNT field);
  - address-range check function.
- Sub-module opb_multireg_capture: snapshot regs, armed/mode/done/count. Parametrised by C_NUM_REGS and C_USER_WIDTH.
- The top holds the OPB FSM and read mux.

Test Plan:
1. Reset, then read offset 0..4 -> all 0. xferAck pulses 1 cycle after select; Sl_DBus=0 outside ack.
2. Write CTRL=0x00000001 (BE=1111), then user_valid with ch0=0xDEADBEEF, ch3=0x12345678 -> reads return those values. CTRL reads armed=0, done=1, count=1.
3. No arm, mode=0, user_valid pulses with new data -> snapshot unchanged, count stays 1.
4. CTRL=0x00000002 (continuous), 3 user_valid pulses -> last value held, count=4.
5. With C_USER_WIDTH=12, user_data ch1=0xFFF -> read 0x00000FFF. Arm write coincident with user_valid -> no capture, armed=1.
6. Held OPB_select for 4 cycles -> xferAck high on cycles 2 and 4 only. Read of offset 0x3C -> 0, acked. Address outside range -> no ack.
